// File: rtl/instr_encoder_pkg.sv
// ============================================================================
//  Module      : instr_encoder_pkg
//  Description : Shared format encodings, RV32I opcode constants and FSM
//                state encodings for the instruction encoder.
//  Revision    : 1.0  - initial release
// ============================================================================
`default_nettype none

package instr_encoder_pkg;

    localparam logic [2:0] FMT_I = 3'd0;
    localparam logic [2:0] FMT_S = 3'd1;
    localparam logic [2:0] FMT_B = 3'd2;
    localparam logic [2:0] FMT_U = 3'd3;
    localparam logic [2:0] FMT_J = 3'd4;

    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    localparam logic [2:0] FUNCT3_ADDI = 3'b000;

    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_SECOND = 1'b1;

endpackage

`default_nettype wire

// File: rtl/instr_encoder_imm_pack.sv
// ============================================================================
//  Module      : imm_pack
//  Description : Scatters a signed immediate into the RV32I I/S/B/U/J bit
//                positions and flags whether it is encodable in that format.
//  Revision    : 1.0  - initial release
// ============================================================================
`default_nettype none

module imm_pack
    import instr_encoder_pkg::*;
(
    input  logic [2:0]  fmt,
    input  logic [31:0] imm,
    output logic [31:0] imm_bits,
    output logic        range_ok
);

    logic w_fits_12;
    logic w_fits_13;
    logic w_fits_21;

    // A value fits in N signed bits when every bit from N-1 upward matches the sign.
    assign w_fits_12 = (&imm[31:11]) || !(|imm[31:11]);
    assign w_fits_13 = (&imm[31:12]) || !(|imm[31:12]);
    assign w_fits_21 = (&imm[31:20]) || !(|imm[31:20]);

    always_comb begin
        imm_bits = 32'b0;
        range_ok = 1'b0;
        case (fmt)
            FMT_I: begin
                imm_bits = {imm[11:0], 20'b0};
                range_ok = w_fits_12;
            end
            FMT_S: begin
                imm_bits = {imm[11:5], 13'b0, imm[4:0], 7'b0};
                range_ok = w_fits_12;
            end
            FMT_B: begin
                imm_bits = {imm[12], imm[10:5], 13'b0, imm[4:1], imm[11], 7'b0};
                range_ok = w_fits_13 && !imm[0];
            end
            FMT_U: begin
                imm_bits = {imm[31:12], 12'b0};
                range_ok = !(|imm[11:0]);
            end
            FMT_J: begin
                imm_bits = {imm[20], imm[10:1], imm[11], imm[19:12], 12'b0};
                range_ok = w_fits_21 && !imm[0];
            end
            default: begin
                imm_bits = 32'b0;
                range_ok = 1'b0;
            end
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/instr_encoder.sv
// ============================================================================
//  Module      : instr_encoder
//  Description : Builds RV32I instruction words from decoded fields and an
//                immediate, with a registered valid/ready output. Defining
//                INSTR_ENCODER_LI_SPLIT_EN expands wide ADDI rd,x0,imm into
//                LUI + ADDI.
//  Revision    : 1.0  - initial release
// ============================================================================
`default_nettype none

module instr_encoder
    import instr_encoder_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      in_fmt,
    input  logic [6:0]      in_opcode,
    input  logic [2:0]      in_funct3,
    input  logic [4:0]      in_rd,
    input  logic [4:0]      in_rs1,
    input  logic [4:0]      in_rs2,
    input  logic [XLEN-1:0] in_imm,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_instr,
    output logic            out_last,
    output logic            err
);

    logic [0:0]  r_state;
    logic [0:0]  w_state_next;
    logic        r_out_valid;
    logic        r_out_last;
    logic        r_err;
    logic [31:0] r_out_instr;
    logic [31:0] r_second_instr;

    logic        w_accept;
    logic        w_range_ok;
    logic        w_split;
    logic        w_ok;
    logic        w_lo_zero;
    logic [19:0] w_hi;
    logic [31:0] w_imm_bits;
    logic [31:0] w_word;
    logic [31:0] w_lui_word;
    logic [31:0] w_addi_word;

    imm_pack u_imm_pack (
        .fmt      (in_fmt),
        .imm      (in_imm),
        .imm_bits (w_imm_bits),
        .range_ok (w_range_ok)
    );

    always_comb begin
        w_word = w_imm_bits | {25'b0, in_opcode};
        case (in_fmt)
            FMT_I:        w_word = w_word | {12'b0, in_rs1, in_funct3, in_rd, 7'b0};
            FMT_S, FMT_B: w_word = w_word | {7'b0, in_rs2, in_rs1, in_funct3, 12'b0};
            FMT_U, FMT_J: w_word = w_word | {20'b0, in_rd, 7'b0};
            default:      w_word = 32'b0;
        endcase
    end

`ifdef INSTR_ENCODER_LI_SPLIT_EN
    assign w_split = (in_fmt == FMT_I) && (in_opcode == OP_IMM) &&
                     (in_funct3 == FUNCT3_ADDI) && (in_rs1 == 5'd0) && !w_range_ok;
`else
    assign w_split = 1'b0;
`endif

    // (imm + 0x800) >> 12 is the upper field plus a carry from bit 11; lo keeps imm[11:0].
    assign w_hi        = in_imm[31:12] + {19'b0, in_imm[11]};
    assign w_lo_zero   = !(|in_imm[11:0]);
    assign w_lui_word  = {w_hi, in_rd, OP_LUI};
    assign w_addi_word = {in_imm[11:0], in_rd, FUNCT3_ADDI, in_rd, OP_IMM};
    assign w_ok        = w_range_ok || w_split;
    assign w_accept    = in_valid && in_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE:   if (w_accept && w_split && !w_lo_zero) w_state_next = ST_SECOND;
            ST_SECOND: if (out_ready) w_state_next = ST_IDLE;
            default:   w_state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        in_ready = (r_state == ST_IDLE) && (!r_out_valid || out_ready);
    end

    // In SECOND the LUI word is always on the output, so out_ready means it was taken.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_valid    <= 1'b0;
            r_out_instr    <= 32'b0;
            r_out_last     <= 1'b0;
            r_second_instr <= 32'b0;
            r_err          <= 1'b0;
        end else begin
            r_err <= w_accept && !w_ok;
            if (r_state == ST_SECOND) begin
                if (out_ready) begin
                    r_out_valid <= 1'b1;
                    r_out_instr <= r_second_instr;
                    r_out_last  <= 1'b1;
                end
            end else if (w_accept && w_ok) begin
                r_out_valid <= 1'b1;
                if (w_split) begin
                    r_out_instr    <= w_lui_word;
                    r_out_last     <= w_lo_zero;
                    r_second_instr <= w_addi_word;
                end else begin
                    r_out_instr <= w_word;
                    r_out_last  <= 1'b1;
                end
            end else if (out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign out_valid = r_out_valid;
    assign out_instr = r_out_instr;
    assign out_last  = r_out_last;
    assign err       = r_err;

endmodule

`default_nettype wire

// File: tb/tb_instr_encoder.sv
// ============================================================================
//  Module      : tb_instr_encoder
//  Description : Directed scoreboard bench for instr_encoder.
//  Revision    : 1.0  - initial release
// ============================================================================
`default_nettype none

module tb_instr_encoder;
    import instr_encoder_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [2:0]  in_fmt = 3'd0;
    logic [6:0]  in_opcode = 7'd0;
    logic [2:0]  in_funct3 = 3'd0;
    logic [4:0]  in_rd = 5'd0;
    logic [4:0]  in_rs1 = 5'd0;
    logic [4:0]  in_rs2 = 5'd0;
    logic [31:0] in_imm = 32'd0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_instr;
    logic        out_last;
    logic        err;

    typedef struct packed {
        logic        is_err;
        logic [31:0] instr;
        logic        last;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        mon_e;
    int          n_total = 0;
    int          n_pass  = 0;
    logic        hold_v = 1'b0;
    logic [31:0] hold_instr;
    logic        hold_last;

    always #5 clk = ~clk;

    instr_encoder #(.XLEN(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_fmt    (in_fmt),
        .in_opcode (in_opcode),
        .in_funct3 (in_funct3),
        .in_rd     (in_rd),
        .in_rs1    (in_rs1),
        .in_rs2    (in_rs2),
        .in_imm    (in_imm),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_instr (out_instr),
        .out_last  (out_last),
        .err       (err)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic push_word(input logic [31:0] instr, input logic last);
        exp_t e;
        e.is_err = 1'b0;
        e.instr  = instr;
        e.last   = last;
        exp_q.push_back(e);
    endtask

    task automatic push_err();
        exp_t e;
        e.is_err = 1'b1;
        e.instr  = 32'b0;
        e.last   = 1'b0;
        exp_q.push_back(e);
    endtask

    task automatic drive(input logic [2:0] f, input logic [6:0] op, input logic [2:0] f3,
                         input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic [31:0] imm);
        in_fmt    = f;
        in_opcode = op;
        in_funct3 = f3;
        in_rd     = rd;
        in_rs1    = rs1;
        in_rs2    = rs2;
        in_imm    = imm;
        in_valid  = 1'b1;
    endtask

    task automatic wait_accept(output int cycles);
        logic acc;
        cycles = 0;
        do begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            cycles++;
        end while (!acc && cycles < 50);
        check("accept_timeout", acc, 1'b1);
    endtask

    task automatic send(input logic [2:0] f, input logic [6:0] op, input logic [2:0] f3,
                        input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic [31:0] imm);
        int c;
        drive(f, op, f3, rd, rs1, rs2, imm);
        wait_accept(c);
        in_valid = 1'b0;
    endtask

    // Output monitor: words are popped when handed off, err pulses pop error entries.
    always @(negedge clk) begin
        if (rst) begin
            hold_v = 1'b0;
        end else begin
            if (hold_v) begin
                check("hold_valid", out_valid, 1'b1);
                check("hold_instr", out_instr, hold_instr);
                check("hold_last", out_last, hold_last);
            end
            if (err) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_err", err, 1'b0);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("err_entry", {1'b1, 32'b0, 1'b0}, mon_e);
                end
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_word", out_valid, 1'b0);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("word", {1'b0, out_instr, out_last}, mon_e);
                end
            end
            hold_v     = out_valid && !out_ready;
            hold_instr = out_instr;
            hold_last  = out_last;
        end
    end

    initial begin
        int c;
        int total;
        int k;

        @(posedge clk);
        #1;
        check("rst_in_ready", in_ready, 1'b1);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_out_instr", out_instr, 32'h0);
        check("rst_out_last", out_last, 1'b0);
        check("rst_err", err, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        push_word(32'hFFF00093, 1'b1); send(FMT_I, OP_IMM, 3'd0, 5'd1, 5'd0, 5'd0, 32'hFFFFFFFF);
        push_word(32'h0020A423, 1'b1); send(FMT_S, OP_STORE, 3'd2, 5'd0, 5'd1, 5'd2, 32'd8);
        push_word(32'hFE000EE3, 1'b1); send(FMT_B, OP_BRANCH, 3'd0, 5'd0, 5'd0, 5'd0, 32'hFFFFFFFC);
        push_word(32'h0000006F, 1'b1); send(FMT_J, OP_JAL, 3'd0, 5'd0, 5'd0, 5'd0, 32'd0);
        push_word(32'h7FF00093, 1'b1); send(FMT_I, OP_IMM, 3'd0, 5'd1, 5'd0, 5'd0, 32'd2047);
        push_word(32'h80000093, 1'b1); send(FMT_I, OP_IMM, 3'd0, 5'd1, 5'd0, 5'd0, 32'hFFFFF800);
        push_word(32'h7E000FE3, 1'b1); send(FMT_B, OP_BRANCH, 3'd0, 5'd0, 5'd0, 5'd0, 32'd4094);
        push_word(32'h8000006F, 1'b1); send(FMT_J, OP_JAL, 3'd0, 5'd0, 5'd0, 5'd0, 32'hFFF00000);
        push_word(32'h123452B7, 1'b1); send(FMT_U, OP_LUI, 3'd0, 5'd5, 5'd0, 5'd0, 32'h12345000);

        push_err(); send(FMT_B, OP_BRANCH, 3'd0, 5'd0, 5'd0, 5'd0, 32'd3);
        push_err(); send(3'd6, OP_IMM, 3'd0, 5'd1, 5'd0, 5'd0, 32'd0);
        push_err(); send(FMT_U, OP_LUI, 3'd0, 5'd5, 5'd0, 5'd0, 32'h12345001);
        push_err(); send(FMT_B, OP_BRANCH, 3'd0, 5'd0, 5'd0, 5'd0, 32'd4096);
        push_err(); send(FMT_J, OP_JAL, 3'd0, 5'd0, 5'd0, 5'd0, 32'h00100000);
`ifdef INSTR_ENCODER_LI_SPLIT_EN
        push_word(32'h123452B7, 1'b0); push_word(32'h67828293, 1'b1);
        send(FMT_I, OP_IMM, FUNCT3_ADDI, 5'd5, 5'd0, 5'd0, 32'h12345678);
        push_word(32'h000012B7, 1'b0); push_word(32'h80028293, 1'b1);
        send(FMT_I, OP_IMM, FUNCT3_ADDI, 5'd5, 5'd0, 5'd0, 32'h00000800);
        push_word(32'h000052B7, 1'b1);
        send(FMT_I, OP_IMM, FUNCT3_ADDI, 5'd5, 5'd0, 5'd0, 32'h00005000);
`else
        push_err(); send(FMT_I, OP_IMM, FUNCT3_ADDI, 5'd1, 5'd0, 5'd0, 32'd2048);
`endif

        // Backpressure: one word stalls while the next request waits.
        out_ready = 1'b0;
        push_word(32'h00100093, 1'b1); send(FMT_I, OP_IMM, 3'd0, 5'd1, 5'd0, 5'd0, 32'd1);
        push_word(32'h00200113, 1'b1); drive(FMT_I, OP_IMM, 3'd0, 5'd2, 5'd0, 5'd0, 32'd2);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_in_ready", in_ready, 1'b0);
            check("bp_out_valid", out_valid, 1'b1);
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        wait_accept(c);

        total = 0;
        push_word(32'h00100093, 1'b1); drive(FMT_I, OP_IMM, 3'd0, 5'd1, 5'd0, 5'd0, 32'd1);
        wait_accept(c); total += c;
        push_word(32'h00200113, 1'b1); drive(FMT_I, OP_IMM, 3'd0, 5'd2, 5'd0, 5'd0, 32'd2);
        wait_accept(c); total += c;
        push_word(32'h00300193, 1'b1); drive(FMT_I, OP_IMM, 3'd0, 5'd3, 5'd0, 5'd0, 32'd3);
        wait_accept(c); total += c;
        push_word(32'h00400213, 1'b1); drive(FMT_I, OP_IMM, 3'd0, 5'd4, 5'd0, 5'd0, 32'd4);
        wait_accept(c); total += c;
        in_valid = 1'b0;
        check("burst_cycles", total, 4);
        repeat (3) @(posedge clk);
        #1;

        // Reset with a word pending on the output.
        out_ready = 1'b0;
`ifdef INSTR_ENCODER_LI_SPLIT_EN
        push_word(32'h123452B7, 1'b0); push_word(32'h67828293, 1'b1);
        send(FMT_I, OP_IMM, FUNCT3_ADDI, 5'd5, 5'd0, 5'd0, 32'h12345678);
`else
        push_word(32'hFFF00093, 1'b1);
        send(FMT_I, OP_IMM, 3'd0, 5'd1, 5'd0, 5'd0, 32'hFFFFFFFF);
`endif
        @(negedge clk);
        check("pend_out_valid", out_valid, 1'b1);
        check("pend_in_ready", in_ready, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("midrst_out_valid", out_valid, 1'b0);
        check("midrst_out_last", out_last, 1'b0);
        check("midrst_in_ready", in_ready, 1'b1);
        exp_q.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        out_ready = 1'b1;
        push_word(32'hFFF00093, 1'b1); send(FMT_I, OP_IMM, 3'd0, 5'd1, 5'd0, 5'd0, 32'hFFFFFFFF);

        k = 0;
        while (exp_q.size() != 0 && k < 20) begin
            @(posedge clk);
            k++;
        end
        repeat (2) @(posedge clk);
        #1;
        check("drain_empty", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire
